// File: rtl/traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_ctrl
// Brief    : Two-road intersection sequencer with one-second prescaler,
//            latched pedestrian requests and flashing-yellow maintenance mode.
// Revision : 1.0
// ============================================================================
module traffic_light_ctrl #(
    parameter int unsigned TICK_DIV    = 50000000,
    parameter int unsigned GREEN_SECS  = 10,
    parameter int unsigned YELLOW_SECS = 3,
    parameter int unsigned ALLRED_SECS = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ped_req_ns,
    input  logic       ped_req_ew,
    input  logic       flash_mode,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk_ns,
    output logic       walk_ew,
    output logic [7:0] secs_left,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED_A  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALLRED_B  = 3'd5,
        FLASH     = 3'd6
    } phase_t;

    localparam logic [31:0] c_TICK_LAST = 32'(TICK_DIV - 1);
    localparam logic [7:0]  c_GREEN     = 8'(GREEN_SECS);
    localparam logic [7:0]  c_YELLOW    = 8'(YELLOW_SECS);
    localparam logic [7:0]  c_ALLRED    = 8'(ALLRED_SECS);
    localparam logic [2:0]  c_RED       = 3'b100;
    localparam logic [2:0]  c_YEL       = 3'b010;
    localparam logic [2:0]  c_GRN       = 3'b001;
    localparam logic [2:0]  c_OFF       = 3'b000;

    phase_t      r_state;
    phase_t      w_state_nxt;
    logic [31:0] r_presc;
    logic [31:0] w_presc_nxt;
    logic [7:0]  r_secs;
    logic [7:0]  w_secs_nxt;
    logic        r_toggle;
    logic        w_toggle_nxt;
    logic        r_pend_ns;
    logic        r_pend_ew;
    logic        w_pend_ns_nxt;
    logic        w_pend_ew_nxt;
    logic        r_walk_ns;
    logic        r_walk_ew;
    logic        w_walk_ns_nxt;
    logic        w_walk_ew_nxt;
    logic [2:0]  r_ns_light;
    logic [2:0]  r_ew_light;
    logic [2:0]  w_ns_light_nxt;
    logic [2:0]  w_ew_light_nxt;
    logic        w_tick;
    logic        w_change;

    function automatic phase_t f_successor(input phase_t s);
        phase_t n;
        case (s)
            ALLRED_B:  n = NS_GREEN;
            NS_GREEN:  n = NS_YELLOW;
            NS_YELLOW: n = ALLRED_A;
            ALLRED_A:  n = EW_GREEN;
            EW_GREEN:  n = EW_YELLOW;
            EW_YELLOW: n = ALLRED_B;
            default:   n = ALLRED_B;
        endcase
        return n;
    endfunction

    function automatic logic [7:0] f_duration(input phase_t s);
        logic [7:0] d;
        case (s)
            NS_GREEN, EW_GREEN:   d = c_GREEN;
            NS_YELLOW, EW_YELLOW: d = c_YELLOW;
            ALLRED_A, ALLRED_B:   d = c_ALLRED;
            default:              d = 8'd0;
        endcase
        return d;
    endfunction

    // Next-state: flash_mode outranks any tick-driven advance.
    always_comb begin
        w_tick      = (r_presc == c_TICK_LAST);
        w_state_nxt = r_state;
        if (r_state == FLASH) begin
            if (!flash_mode) begin
                w_state_nxt = ALLRED_B;
            end
        end else if (flash_mode) begin
            w_state_nxt = FLASH;
        end else if (r_state == phase_t'(3'd7)) begin
            w_state_nxt = ALLRED_B;
        end else if (w_tick && (r_secs == 8'd1)) begin
            w_state_nxt = f_successor(r_state);
        end
        w_change = (w_state_nxt != r_state);
    end

    // Countdown, prescaler, flash toggle and pedestrian bookkeeping.
    always_comb begin
        w_presc_nxt   = r_presc + 32'd1;
        w_secs_nxt    = r_secs;
        w_toggle_nxt  = r_toggle;
        w_pend_ns_nxt = r_pend_ns | ped_req_ns;
        w_pend_ew_nxt = r_pend_ew | ped_req_ew;
        w_walk_ns_nxt = r_walk_ns;
        w_walk_ew_nxt = r_walk_ew;

        if (w_change) begin
            w_presc_nxt   = 32'd0;
            w_secs_nxt    = f_duration(w_state_nxt);
            w_toggle_nxt  = 1'b0;
            w_walk_ns_nxt = 1'b0;
            w_walk_ew_nxt = 1'b0;
            if (w_state_nxt == NS_GREEN) begin
                w_walk_ns_nxt = r_pend_ns | ped_req_ns;
                w_pend_ns_nxt = 1'b0;
            end
            if (w_state_nxt == EW_GREEN) begin
                w_walk_ew_nxt = r_pend_ew | ped_req_ew;
                w_pend_ew_nxt = 1'b0;
            end
        end else if (w_tick) begin
            w_presc_nxt = 32'd0;
            if (r_state == FLASH) begin
                w_toggle_nxt = ~r_toggle;
            end else if (r_secs > 8'd1) begin
                w_secs_nxt = r_secs - 8'd1;
            end
        end
    end

    // Lamp decode uses the upcoming state so the lamps register with it.
    always_comb begin
        w_ns_light_nxt = c_RED;
        w_ew_light_nxt = c_RED;
        case (w_state_nxt)
            NS_GREEN:  w_ns_light_nxt = c_GRN;
            NS_YELLOW: w_ns_light_nxt = c_YEL;
            EW_GREEN:  w_ew_light_nxt = c_GRN;
            EW_YELLOW: w_ew_light_nxt = c_YEL;
            FLASH: begin
                w_ns_light_nxt = w_toggle_nxt ? c_YEL : c_OFF;
                w_ew_light_nxt = w_toggle_nxt ? c_YEL : c_OFF;
            end
            default: begin
                w_ns_light_nxt = c_RED;
                w_ew_light_nxt = c_RED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ALLRED_B;
            r_presc    <= 32'd0;
            r_secs     <= c_ALLRED;
            r_toggle   <= 1'b0;
            r_pend_ns  <= 1'b0;
            r_pend_ew  <= 1'b0;
            r_walk_ns  <= 1'b0;
            r_walk_ew  <= 1'b0;
            r_ns_light <= c_RED;
            r_ew_light <= c_RED;
        end else begin
            r_state    <= w_state_nxt;
            r_presc    <= w_presc_nxt;
            r_secs     <= w_secs_nxt;
            r_toggle   <= w_toggle_nxt;
            r_pend_ns  <= w_pend_ns_nxt;
            r_pend_ew  <= w_pend_ew_nxt;
            r_walk_ns  <= w_walk_ns_nxt;
            r_walk_ew  <= w_walk_ew_nxt;
            r_ns_light <= w_ns_light_nxt;
            r_ew_light <= w_ew_light_nxt;
        end
    end

    assign ns_light  = r_ns_light;
    assign ew_light  = r_ew_light;
    assign walk_ns   = r_walk_ns;
    assign walk_ew   = r_walk_ew;
    assign secs_left = r_secs;
    assign phase     = r_state;

endmodule
`default_nettype wire

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
Hardware sequencer for a two-road (north-south / east-west) intersection.
- A prescaler derived from the system clock produces one-second ticks.
- A phase FSM steps through green/yellow/all-red phases, serves latched pedestrian requests and supports a flashing-yellow maintenance mode.
- Outputs drive board LEDs directly. `secs_left` feeds the HEX countdown display, either through the Nios PIO or a 7-seg decoder.

Parameters:
- TICK_DIV, 50000000, clk cycles per one-second tick (legal range 2..2^32-1)
- GREEN_SECS, 10, green phase length in ticks (legal range 1..255)
- YELLOW_SECS, 3, yellow phase length in ticks (legal range 1..255)
- ALLRED_SECS, 1, all-red clearance length in ticks (legal range 1..255)

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- ped_req_ns  in  1  pedestrian button, NS crossing; level or pulse, sampled every cycle
- ped_req_ew  in  1  pedestrian button, EW crossing
- flash_mode  in  1  1 = flashing-yellow maintenance mode
- ns_light  out  3  {red,yellow,green}, one-hot or all-zero
- ew_light  out  3  {red,yellow,green}
- walk_ns  out  1  NS walk lamp
- walk_ew  out  1  EW walk lamp
- secs_left  out  8  ticks remaining in current phase
- phase  out  3  current FSM state encoding, for debug/PIO

Behaviour:
- Reset (reset_n=0 at a clk edge): phase=ALLRED_B, secs_left=ALLRED_SECS, prescaler=0, pend_ns=pend_ew=0, walk_ns=walk_ew=0, ns_light=ew_light=3'b100, flash toggle=0.
- Encodings: NS_GREEN=0, NS_YELLOW=1, ALLRED_A=2, EW_GREEN=3, EW_YELLOW=4, ALLRED_B=5, FLASH=6.
- Normal cycle: ALLRED_B -> NS_GREEN -> NS_YELLOW -> ALLRED_A -> EW_GREEN -> EW_YELLOW -> ALLRED_B.
- Prescaler:
  - Counts 0..TICK_DIV-1 and asserts an internal tick in the cycle it equals TICK_DIV-1.
  - Cleared to 0 on every phase change, so every phase lasts exactly duration*TICK_DIV cycles.
- Phase countdown:
  - On entry, secs_left loads the phase duration.
  - On a tick with secs_left>1, secs_left decrements.
  - On a tick with secs_left==1, the FSM advances. The next state and its loaded duration are visible the following cycle.
  - secs_left never reads 0 outside FLASH.
- Lights:
  - NS_GREEN: ns=001, ew=100.
  - NS_YELLOW: ns=010, ew=100.
  - ALLRED_A and ALLRED_B: both 100.
  - EW phases mirror the NS phases.
  - Never green or yellow on both roads at once.
- Pedestrian handling:
  - pend_x is set by any cycle with ped_req_x=1.
  - On the transition into X_GREEN, walk_x is set to (pend_x | ped_req_x) and pend_x is cleared. A request coincident with entry is served, not held over.
  - walk_x stays high for the whole X_GREEN phase and clears on the transition out of X_GREEN.
  - Requests during X_GREEN re-set pend_x for the next X_GREEN.
- Flash mode:
  - flash_mode=1 is checked every cycle in any non-FLASH state and causes an immediate move to FLASH next cycle (mid-phase abort allowed).
  - In FLASH: secs_left=0, walk lamps 0, pending requests retained.
  - The flash toggle flips on each tick. Both roads show 010 when toggle=1 and 000 when toggle=0.
  - Toggle=0 on entry.
  - flash_mode=0 in FLASH -> ALLRED_B next cycle, with secs_left=ALLRED_SECS and prescaler=0.
- Simultaneous events: flash_mode has priority over a tick-driven phase advance.
- Reset mid-operation: the reset state applies regardless of current state, including FLASH.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Cycle timing (TICK_DIV=4, GREEN=2, YELLOW=1, ALLRED=1): release reset -> ALLRED_B 4 cycles, NS_GREEN 8 cycles (secs_left 2,2,2,2,1,1,1,1), NS_YELLOW 4, ALLRED_A 4, EW_GREEN 8, EW_YELLOW 4, then back to ALLRED_B. Checker asserts no overlapping non-red lights on any cycle.
- Pedestrian request: pulse ped_req_ew for 1 cycle during NS_GREEN -> walk_ew=1 exactly for all EW_GREEN cycles; walk_ns stays 0. Next EW_GREEN has walk_ew=0.
- Coincident request: ped_req_ns=1 only on the ALLRED_B->NS_GREEN transition edge -> walk_ns=1 for that NS_GREEN; pend_ns is 0 afterwards.
- Flash entry/exit: assert flash_mode mid NS_GREEN -> next cycle phase=6 and lights 000. Lights toggle to 010 after 4 cycles and back every 4 cycles. Deassert -> phase=5, secs_left=1, both red.
- Tick/flash collision: assert flash_mode on the same cycle as the NS_YELLOW final tick -> phase=6, not ALLRED_A.
- Reset mid-phase: pull reset_n low during EW_YELLOW for 1 cycle -> phase=5, both red, walk=0, secs_left=ALLRED_SECS. Pending requests are cleared.
